pipe_mem_stage: RTL and testbench

- Memory stage of the 5-stage pipeline, directly downstream of the execute stage.
- Contains the EXE/MEM pipeline register. It consumes the execute-stage outputs: ALU result/address, store data, destination register and control bits.
- Performs load/store accesses to data memory over a variable-latency req/ack bus.
- Stalls upstream stages while an access is outstanding. Presents completed results to the MEM/WB register with a one-cycle done strobe.

---
 rtl/pipe_mem_stage.sv | 137 +++++++++++++
 tb/tb_pipe_mem_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_stage.sv
// Memory stage of the 5-stage pipeline.
// Holds the EXE/MEM pipeline register and runs loads and stores over a
// variable-latency req/ack data-memory bus. Upstream stages are frozen while
// an access is outstanding. Each finished instruction is handed to MEM/WB
// with a one-cycle mdone strobe.
`timescale 1ns/1ps

module pipe_mem_stage #(
    parameter int unsigned TIMEOUT = 16   // legal range 2..255
) (
    input  logic        clock,
    input  logic        reset,
    // execute-stage outputs
    input  logic        evalid,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    input  logic [4:0]  ern,
    // data-memory bus
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    // pipeline control and MEM/WB results
    output logic        mstall,
    output logic        mdone,
    output logic        merr,
    output logic        mwreg,
    output logic        mm2reg,
    output logic [4:0]  mrn,
    output logic [31:0] malu,
    output logic [31:0] mmo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The last WAIT cycle, counted from 0, in which an ack is still accepted.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        valid_q;
    logic        wreg_q;
    logic        m2reg_q;
    logic        wmem_q;
    logic [31:0] alu_q;
    logic [31:0] b_q;
    logic [4:0]  rn_q;
    logic [31:0] mmo_q;
    logic        fault_q;
    logic [7:0]  cnt_q;

    // A memory op in execute. It is misaligned when the low address bits are set.
    logic e_mem_op;
    logic e_misalign;
    logic in_wait;

    assign e_mem_op   = evalid & (em2reg | ewmem);
    assign e_misalign = e_mem_op & (ealu[1:0] != 2'b00);
    assign in_wait    = (state_q == S_WAIT);

    // FSM and M register. It captures from execute whenever it is not stalled,
    // and otherwise tracks the outstanding access.
    // NOTE: all state here is written with non-blocking assignments, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
            alu_q   <= '0;
            b_q     <= '0;
            rn_q    <= '0;
            mmo_q   <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (dmem_ack) begin
                        // An ack takes priority over a timeout in the same cycle.
                        if (m2reg_q) begin
                            mmo_q <= dmem_rdata;
                        end
                        state_q <= S_DONE;
                    end else if (cnt_q == LAST_WAIT) begin
                        fault_q <= 1'b1;
                        mmo_q   <= '0;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    // IDLE or DONE: the stage is free, so take the next instruction.
                    valid_q <= evalid;
                    wreg_q  <= ewreg;
                    m2reg_q <= em2reg;
                    wmem_q  <= ewmem;
                    alu_q   <= ealu;
                    b_q     <= eb;
                    rn_q    <= ern;
                    mmo_q   <= '0;
                    fault_q <= e_misalign;
                    cnt_q   <= '0;
                    state_q <= (e_mem_op && !e_misalign) ? S_WAIT : S_IDLE;
                end
            endcase
        end
    end

    // The bus is driven only during WAIT, so it stays quiet otherwise and drops
    // as soon as reset clears the state.
    assign dmem_req   = in_wait;
    assign dmem_we    = in_wait & wmem_q;
    assign dmem_addr  = in_wait ? alu_q : 32'd0;
    assign dmem_wdata = in_wait ? b_q   : 32'd0;

    assign mstall = in_wait;
    // DONE is only ever reached with a valid instruction in M.
    assign mdone  = ((state_q == S_IDLE) & valid_q) | (state_q == S_DONE);
    assign merr   = mdone & fault_q;
    assign mwreg  = valid_q & wreg_q & ~fault_q;
    assign mm2reg = m2reg_q;
    assign mrn    = rn_q;
    assign malu   = alu_q;
    assign mmo    = mmo_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Self-checking bench for pipe_mem_stage. A stimulus process issues directed
// instructions and queues the hand-computed results. A memory responder
// services the bus. A monitor checks every mdone against the queue.
`timescale 1ns/1ps

module tb_pipe_mem_stage;

    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        evalid, ewreg, em2reg, ewmem;
    logic [31:0] ealu, eb;
    logic [4:0]  ern;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mstall, mdone, merr, mwreg, mm2reg;
    logic [4:0]  mrn;
    logic [31:0] malu, mmo;

    pipe_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .evalid     (evalid),
        .ewreg      (ewreg),
        .em2reg     (em2reg),
        .ewmem      (ewmem),
        .ealu       (ealu),
        .eb         (eb),
        .ern        (ern),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .mstall     (mstall),
        .mdone      (mdone),
        .merr       (merr),
        .mwreg      (mwreg),
        .mm2reg     (mm2reg),
        .mrn        (mrn),
        .malu       (malu),
        .mmo        (mmo)
    );

    initial forever #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected MEM/WB result. due is the cycle number in which mdone must appear.
    typedef struct {
        logic        err;
        logic        wreg;
        logic        m2reg;
        logic [4:0]  rn;
        logic [31:0] alu;
        logic [31:0] mmo;
        int          due;
    } exp_t;

    // Expected bus transaction. delay: ack in that WAIT cycle; 0 = never ack
    // (timeout); -1 = abandoned by reset.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } bus_t;

    exp_t sb[$];
    bus_t bq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Monitor: pops one expectation for every mdone strobe.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            if (mdone) begin
                if (sb.size() == 0) begin
                    check("spurious_mdone", 32'(mdone), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", 32'(cyc),    32'(e.due));
                    check("merr",       32'(merr),   32'(e.err));
                    check("mwreg",      32'(mwreg),  32'(e.wreg));
                    check("mm2reg",     32'(mm2reg), 32'(e.m2reg));
                    check("mrn",        32'(mrn),    32'(e.rn));
                    check("malu",       malu,        e.alu);
                    check("mmo",        mmo,         e.mmo);
                    check("stall_at_done", 32'(mstall), 32'd0);
                end
            end else begin
                check("merr_without_done", 32'(merr), 32'd0);
            end
        end
    end

    // Memory responder: checks the request fields and acks after the set delay.
    initial begin
        bit   active = 0;
        int   cnt    = 0;
        bus_t cur;
        cur = '{we: 1'b0, addr: 32'd0, wdata: 32'd0, rdata: 32'd0, delay: -1};
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        forever begin
            @(negedge clock);
            dmem_ack = 1'b0;
            if (dmem_req) begin
                if (!active) begin
                    active = 1;
                    cnt    = 0;
                    if (bq.size() == 0) begin
                        check("unexpected_req", 32'(dmem_req), 32'd0);
                        cur = '{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata, rdata: 32'd0, delay: -1};
                    end else begin
                        cur = bq.pop_front();
                    end
                end
                cnt++;
                check("bus_we",    32'(dmem_we), 32'(cur.we));
                check("bus_addr",  dmem_addr,    cur.addr);
                check("bus_wdata", dmem_wdata,   cur.wdata);
                check("stall_with_req", 32'(mstall), 32'd1);
                if (cur.delay > 0 && cnt == cur.delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = cur.rdata;
                end
            end else if (active) begin
                active = 0;
                if (cur.delay >= 0) begin
                    check("req_cycles", 32'(cnt), (cur.delay == 0) ? 32'(TIMEOUT) : 32'(cur.delay));
                end
                if (cur.delay == 0) begin
                    // A stray ack during DONE must be ignored.
                    dmem_ack   = 1'b1;
                    dmem_rdata = 32'hBAD0_0BAD;
                end
            end
        end
    end

    // Issue one instruction after any stall has cleared. It is captured at the next rising edge.
    task automatic issue(input logic v, input logic wr, input logic m2, input logic wm,
                         input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                         input int lat, input logic x_err, input logic x_wreg,
                         input logic [31:0] x_mmo);
        int guard = 0;
        @(negedge clock);
        while (mstall && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check("stall_released", 32'(mstall), 32'd0);
        evalid = v;  ewreg = wr;  em2reg = m2;  ewmem = wm;
        ealu   = alu; eb   = b;   ern    = rn;
        if (v) begin
            sb.push_back('{err: x_err, wreg: x_wreg, m2reg: m2, rn: rn,
                           alu: alu, mmo: x_mmo, due: cyc + 1 + lat});
        end
    endtask

    task automatic bubble();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(negedge clock);
            guard++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mdone"},  32'(mdone),  32'd0);
        check({tag, "_merr"},   32'(merr),   32'd0);
        check({tag, "_mstall"}, 32'(mstall), 32'd0);
        check({tag, "_req"},    32'(dmem_req), 32'd0);
        check({tag, "_we"},     32'(dmem_we),  32'd0);
        check({tag, "_addr"},   dmem_addr,   32'd0);
        check({tag, "_wdata"},  dmem_wdata,  32'd0);
        check({tag, "_mwreg"},  32'(mwreg),  32'd0);
        check({tag, "_mm2reg"}, 32'(mm2reg), 32'd0);
        check({tag, "_mrn"},    32'(mrn),    32'd0);
        check({tag, "_malu"},   malu,        32'd0);
        check({tag, "_mmo"},    mmo,         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        evalid = 1'b0; ewreg = 1'b0; em2reg = 1'b0; ewmem = 1'b0;
        ealu = 32'd0; eb = 32'd0; ern = 5'd0;
        repeat (2) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;

        // ALU op: done the cycle after capture, with no bus activity.
        issue(1, 1, 0, 0, 32'h0000_1234, 32'd0, 5'd5, 0, 1'b0, 1'b1, 32'd0);

        // Aligned load, acked in the 3rd WAIT cycle.
        bq.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'd0, rdata: 32'hDEAD_BEEF, delay: 3});
        issue(1, 1, 1, 0, 32'h100, 32'd0, 5'd8, 3, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Store, acked in the 1st WAIT cycle. The rdata returned must not reach mmo.
        bq.push_back('{we: 1'b1, addr: 32'h204, wdata: 32'hCAFE_0001, rdata: 32'h5555_5555, delay: 1});
        issue(1, 0, 0, 1, 32'h204, 32'hCAFE_0001, 5'd0, 1, 1'b0, 1'b0, 32'd0);

        // Misaligned load: no request. It faults and suppresses the register write.
        issue(1, 1, 1, 0, 32'h102, 32'd0, 5'd9, 0, 1'b1, 1'b0, 32'd0);

        // Load that is never acked: times out after TIMEOUT WAIT cycles.
        bq.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'd0, rdata: 32'd0, delay: 0});
        issue(1, 1, 1, 0, 32'h300, 32'd0, 5'd10, TIMEOUT, 1'b1, 1'b0, 32'd0);
        bubble();
        bubble();

        // Back-to-back load/load, then a bubble, an ALU op and a misaligned store.
        bq.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0000_0011, rdata: 32'h1111_1111, delay: 2});
        issue(1, 1, 1, 0, 32'h400, 32'h0000_0011, 5'd11, 2, 1'b0, 1'b1, 32'h1111_1111);
        bq.push_back('{we: 1'b0, addr: 32'h404, wdata: 32'd0, rdata: 32'h2222_2222, delay: 1});
        issue(1, 1, 1, 0, 32'h404, 32'd0, 5'd12, 1, 1'b0, 1'b1, 32'h2222_2222);
        bubble();
        issue(1, 1, 0, 0, 32'h0000_ABCD, 32'd0, 5'd13, 0, 1'b0, 1'b1, 32'd0);
        issue(1, 0, 0, 1, 32'h201, 32'h77, 5'd14, 0, 1'b1, 1'b0, 32'd0);
        bubble();
        drain("scoreboard_drained");

        // Reset during WAIT: the request and the stall drop without waiting for a clock edge.
        bq.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'd0, rdata: 32'd0, delay: -1});
        @(negedge clock);
        evalid = 1'b1; ewreg = 1'b1; em2reg = 1'b1; ewmem = 1'b0;
        ealu = 32'h500; eb = 32'd0; ern = 5'd15;
        @(negedge clock);
        @(negedge clock);
        check("req_before_reset", 32'(dmem_req), 32'd1);
        #2;
        reset  = 1'b1;
        evalid = 1'b0; em2reg = 1'b0; ewreg = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(negedge clock);
        reset = 1'b0;

        // The stage recovers after reset.
        issue(1, 1, 0, 0, 32'h0000_0042, 32'd0, 5'd3, 0, 1'b0, 1'b1, 32'd0);
        bubble();
        bubble();
        drain("scoreboard_drained_end");
        check("bus_queue_drained", 32'(bq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
